// File: rtl/exc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exc_sequencer
//  Purpose  : Exception/ERET sequencer for the MIPS core. Arbitrates trap
//             sources, masks them with CP0 Status, stalls the core while an
//             exception is taken, strobes CP0 and redirects the PC.
//  Revision : 1.0  initial release
// ============================================================================
module exc_sequencer #(
    parameter logic [31:0] VEC_ADDR     = 32'h00400004,
    parameter int          DRAIN_CYCLES = 1,
    parameter logic [4:0]  C_SYSCALL    = 5'd8,
    parameter logic [4:0]  C_BREAK      = 5'd9,
    parameter logic [4:0]  C_TEQ        = 5'd13,
    parameter logic [4:0]  C_INT        = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        req_syscall,
    input  logic        req_break,
    input  logic        req_teq,
    input  logic        req_int,
    input  logic        eret_req,
    input  logic [31:0] pc_in,
    input  logic [31:0] status_in,
    input  logic [31:0] epc_in,
    output logic        stall,
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic        in_handler,
    output logic [7:0]  exc_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_SAVE    = 3'd2,
        S_REDIR   = 3'd3,
        S_HANDLER = 3'd4,
        S_RET     = 3'd5
    } state_t;

    // Drain counter reload; unused when the drain phase is skipped entirely.
    localparam logic [3:0] C_DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [4:0]  r_cause;
    logic [31:0] r_pc;
    logic        r_int_pending;
    logic        r_ret_block;

    logic        w_sys;
    logic        w_brk;
    logic        w_teq;
    logic        w_sync;
    logic        w_int_ok;
    logic        w_accept;
    logic        w_eret;
    logic [4:0]  w_cause;
    logic        w_unused;

    // Upper Status bits carry nothing this block cares about.
    assign w_unused = &{1'b0, status_in[31:4]};

    // Trap arbitration and next-state selection.
    always_comb begin
        w_sys    = instr_valid & req_syscall & status_in[1];
        w_brk    = instr_valid & req_break   & status_in[2];
        w_teq    = instr_valid & req_teq     & status_in[3];
        w_sync   = w_sys | w_brk | w_teq;
        // The IDLE cycle right after an ERET never takes an interrupt so the
        // returning instruction gets to issue once.
        w_int_ok = r_int_pending & status_in[0] & ~w_sync & ~r_ret_block;
        w_accept = (r_state == S_IDLE) & (w_sync | w_int_ok);
        w_eret   = instr_valid & eret_req;

        if (w_sys)      w_cause = C_SYSCALL;
        else if (w_brk) w_cause = C_BREAK;
        else if (w_teq) w_cause = C_TEQ;
        else            w_cause = C_INT;

        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)    w_next = (DRAIN_CYCLES == 0) ? S_SAVE : S_DRAIN;
                else if (w_eret) w_next = S_RET;
            end
            S_DRAIN:   if (r_cnt == 4'd0) w_next = S_SAVE;
            S_SAVE:    w_next = S_REDIR;
            S_REDIR:   w_next = S_HANDLER;
            S_HANDLER: if (w_eret) w_next = S_RET;
            S_RET:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State, captured trap context and registered outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_cause       <= 5'd0;
            r_pc          <= 32'd0;
            r_int_pending <= 1'b0;
            r_ret_block   <= 1'b0;
            stall         <= 1'b0;
            cp0_exception <= 1'b0;
            cp0_eret      <= 1'b0;
            cp0_cause     <= 5'd0;
            cp0_pc        <= 32'd0;
            pc_redirect   <= 1'b0;
            redirect_addr <= 32'd0;
            in_handler    <= 1'b0;
            exc_count     <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_ret_block <= (r_state == S_RET);

            if (w_accept) begin
                r_cnt   <= C_DRAIN_LOAD;
                r_cause <= w_cause;
                r_pc    <= pc_in;
            end else if (r_state == S_DRAIN && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // A new interrupt level always wins over the clear in SAVE.
            if (req_int)
                r_int_pending <= 1'b1;
            else if (r_state == S_SAVE && r_cause == C_INT)
                r_int_pending <= 1'b0;

            if (w_next == S_SAVE && exc_count != 8'hFF)
                exc_count <= exc_count + 8'd1;

            stall         <= (w_next == S_DRAIN) || (w_next == S_SAVE) ||
                             (w_next == S_REDIR) || (w_next == S_RET);
            cp0_exception <= (w_next == S_SAVE) || (w_next == S_RET);
            cp0_eret      <= (w_next == S_RET);
            pc_redirect   <= (w_next == S_REDIR) || (w_next == S_RET);
            in_handler    <= (w_next == S_HANDLER);

            if (w_next == S_REDIR)    redirect_addr <= VEC_ADDR;
            else if (w_next == S_RET) redirect_addr <= epc_in;
            else                      redirect_addr <= 32'd0;

            if (w_next == S_IDLE) begin
                cp0_cause <= 5'd0;
                cp0_pc    <= 32'd0;
            end else if (w_accept) begin
                cp0_cause <= w_cause;
                cp0_pc    <= pc_in;
            end else begin
                cp0_cause <= r_cause;
                cp0_pc    <= r_pc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exc_sequencer
//  Purpose  : Scoreboard bench for exc_sequencer; directed trap/eret vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exc_sequencer;

    localparam logic [31:0] C_VEC = 32'h00400004;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, req_syscall, req_break, req_teq, req_int, eret_req;
    logic [31:0] pc_in, status_in, epc_in;
    logic        stall, cp0_exception, cp0_eret, pc_redirect, in_handler;
    logic [4:0]  cp0_cause;
    logic [31:0] cp0_pc, redirect_addr;
    logic [7:0]  exc_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic        exc;
        logic        eret;
        logic        redir;
        logic [4:0]  cause;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        chk_cp;
    } evt_t;

    evt_t q[$];
    evt_t e;

    exc_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .req_syscall(req_syscall), .req_break(req_break),
        .req_teq(req_teq), .req_int(req_int), .eret_req(eret_req),
        .pc_in(pc_in), .status_in(status_in), .epc_in(epc_in),
        .stall(stall), .cp0_exception(cp0_exception), .cp0_eret(cp0_eret),
        .cp0_cause(cp0_cause), .cp0_pc(cp0_pc), .pc_redirect(pc_redirect),
        .redirect_addr(redirect_addr), .in_handler(in_handler), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe cycle must match the next expected event.
    always @(negedge clk) begin
        if (cp0_exception || cp0_eret || pc_redirect) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: cyc=%0d exc=%b eret=%b redir=%b addr=%h, none expected",
                         cyc, cp0_exception, cp0_eret, pc_redirect, redirect_addr);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.exc != cp0_exception || e.eret != cp0_eret ||
                    e.redir != pc_redirect || e.addr != redirect_addr ||
                    (e.chk_cp && (e.cause != cp0_cause || e.pc != cp0_pc))) begin
                    bad++;
                    $display("FAIL strobe_evt: got cyc=%0d exc=%b eret=%b redir=%b addr=%h cause=%0d pc=%h; want cyc=%0d exc=%b eret=%b redir=%b addr=%h cause=%0d pc=%h",
                             cyc, cp0_exception, cp0_eret, pc_redirect, redirect_addr, cp0_cause, cp0_pc,
                             e.cyc, e.exc, e.eret, e.redir, e.addr, e.cause, e.pc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc=%0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        instr_valid = 1'b0; req_syscall = 1'b0; req_break = 1'b0;
        req_teq = 1'b0; req_int = 1'b0; eret_req = 1'b0;
    endtask

    // Accept sampled on the edge after cycle a: SAVE at a+2, REDIR at a+3.
    task automatic push_exc(input int a, input logic [4:0] c, input logic [31:0] p);
        q.push_back('{a + 2, 1'b1, 1'b0, 1'b0, c, p, 32'd0, 1'b1});
        q.push_back('{a + 3, 1'b0, 1'b0, 1'b1, c, p, C_VEC, 1'b0});
    endtask

    task automatic push_ret(input int a, input logic [31:0] epc);
        q.push_back('{a + 1, 1'b1, 1'b1, 1'b1, 5'd0, 32'd0, epc, 1'b0});
    endtask

    // Syscall from IDLE, ending in the first HANDLER cycle.
    task automatic take_syscall(input logic [31:0] p);
        pc_in = p; instr_valid = 1'b1; req_syscall = 1'b1;
        push_exc(cyc, 5'd8, p);
        tick(1); clr(); tick(3);
    endtask

    // ERET from HANDLER, ending in the first IDLE cycle.
    task automatic do_eret(input logic [31:0] epc);
        epc_in = epc; instr_valid = 1'b1; eret_req = 1'b1;
        push_ret(cyc, epc);
        tick(1); clr(); tick(1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {22'd0, stall, cp0_exception, cp0_eret, cp0_cause, pc_redirect, in_handler}, 32'd0);
        chk({nm, "_pc"}, cp0_pc, 32'd0);
        chk({nm, "_addr"}, redirect_addr, 32'd0);
        chk({nm, "_cnt"}, {24'd0, exc_count}, 32'd0);
    endtask

    initial begin
        clr();
        pc_in = 32'd0; status_in = 32'd0; epc_in = 32'd0;
        rst = 1'b1;
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Basic syscall into the handler.
        status_in = 32'h2;
        pc_in = 32'h00400100; instr_valid = 1'b1; req_syscall = 1'b1;
        push_exc(cyc, 5'd8, 32'h00400100);
        tick(1); clr();
        chk("sys_stall_drain", {31'd0, stall}, 32'd1);
        tick(1);
        chk("sys_stall_save", {31'd0, stall}, 32'd1);
        tick(2);
        chk("sys_in_handler", {31'd0, in_handler}, 32'd1);
        chk("sys_handler_nostall", {31'd0, stall}, 32'd0);
        chk("sys_count", {24'd0, exc_count}, 32'd1);

        // Trap inside the handler is ignored; eret returns to EPC.
        status_in = 32'hF;
        instr_valid = 1'b1; req_teq = 1'b1;
        tick(1); clr();
        chk("teq_ignored_handler", {31'd0, in_handler}, 32'd1);
        chk("teq_ignored_stall", {31'd0, stall}, 32'd0);
        epc_in = 32'h00400104; instr_valid = 1'b1; eret_req = 1'b1;
        push_ret(cyc, 32'h00400104);
        tick(1); clr();
        chk("ret_stall", {31'd0, stall}, 32'd1);
        chk("ret_not_handler", {31'd0, in_handler}, 32'd0);
        tick(1);
        chk("ret_idle_stall", {31'd0, stall}, 32'd0);
        chk("ret_count", {24'd0, exc_count}, 32'd1);

        // Masked break is dropped.
        status_in = 32'h1;
        instr_valid = 1'b1; req_break = 1'b1;
        tick(1); clr();
        chk("brk_masked_stall", {31'd0, stall}, 32'd0);
        tick(2);
        chk("brk_masked_stall2", {31'd0, stall}, 32'd0);
        chk("brk_masked_count", {24'd0, exc_count}, 32'd1);
        chk("idle_cause", {27'd0, cp0_cause}, 32'd0);
        chk("idle_pc", cp0_pc, 32'd0);

        // Simultaneous syscall+break+interrupt: syscall wins, interrupt stays pending.
        status_in = 32'hF;
        pc_in = 32'h00400180;
        instr_valid = 1'b1; req_syscall = 1'b1; req_break = 1'b1; req_int = 1'b1;
        push_exc(cyc, 5'd8, 32'h00400180);
        tick(1); clr(); tick(3);
        chk("prio_in_handler", {31'd0, in_handler}, 32'd1);
        chk("prio_count", {24'd0, exc_count}, 32'd2);
        pc_in = 32'h00400200;
        do_eret(32'h00400184);
        chk("int_blocked_after_ret", {31'd0, stall}, 32'd0);
        push_exc(cyc + 1, 5'd0, 32'h00400200);
        tick(1);
        chk("int_accept_cycle_nostall", {31'd0, stall}, 32'd0);
        tick(1);
        chk("int_drain_stall", {31'd0, stall}, 32'd1);
        tick(3);
        chk("int_in_handler", {31'd0, in_handler}, 32'd1);
        chk("int_count", {24'd0, exc_count}, 32'd3);
        do_eret(32'h00400204);
        tick(3);
        chk("int_cleared", {31'd0, stall}, 32'd0);

        // Reset during DRAIN: no CP0 save strobe ever appears.
        status_in = 32'h2;
        pc_in = 32'h00400280; instr_valid = 1'b1; req_syscall = 1'b1;
        tick(1); clr();
        chk("rst_drain_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk_all_zero("rst_in_drain");
        rst = 1'b0;
        tick(5);
        chk("rst_drain_idle", {31'd0, stall}, 32'd0);

        // Saturation of the exception counter.
        for (int i = 0; i < 256; i++) begin
            take_syscall(32'h00400300);
            do_eret(32'h00400304);
            if (i == 254) chk("count_255", {24'd0, exc_count}, 32'd255);
        end
        chk("count_saturated", {24'd0, exc_count}, 32'd255);

        tick(2);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
